// File: rtl/board_state_scanner.sv
// DIM x DIM board RAM with a one-line-per-cycle win/draw scan engine and busy/done handshake.
// Optional `WRITE_PROTECT_EN: writes to occupied cells are rejected and all rejects pulse werr.
module board_state_scanner #(
    parameter int unsigned DIM    = 3,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              we,
    input  logic [1:0]        data,
    input  logic [ADDR_W-1:0] addr,
    output logic [1:0]        Q,
    output logic [1:0]        state_final,
    output logic              busy,
    output logic              done,
    output logic              game_over,
    output logic              werr
);
    localparam int unsigned NCELLS = DIM * DIM;
    localparam int unsigned NLINES = 2 * DIM + 2;
    localparam int unsigned IDX_W  = $clog2(NLINES);
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NCELLS);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NLINES - 1);
    localparam logic [IDX_W-1:0]  ROW_END   = IDX_W'(DIM);

    typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_e;

    state_e            state_q, state_d;
    logic [1:0]        ram_q [DEPTH];
    logic [1:0]        ram_d [DEPTH];
    logic [ADDR_W-1:0] addr_reg_q, addr_reg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              p1_q, p1_d, p2_q, p2_d, full_q, full_d;
    logic [1:0]        state_final_q, state_final_d;
    logic              done_q, done_d;
    logic              addr_ok, wr_ok, last_line;
    logic              line_p1, line_p2, line_nz;

    // RAM is sized to the full address space so any address indexes it directly;
    // entries 0 and above DIM*DIM are never written.
    assign addr_ok   = (addr != '0) && (addr <= LAST_ADDR);
    assign last_line = (idx_q == LAST_IDX);

`ifdef WRITE_PROTECT_EN
    logic werr_q, werr_d;
    assign wr_ok  = we && addr_ok && !game_over && (ram_q[addr] == 2'b00);
    assign werr_d = we && !wr_ok;
    assign werr   = werr_q;
    always_ff @(posedge clk or posedge clear) begin
        if (clear) werr_q <= 1'b0;
        else       werr_q <= werr_d;
    end
`else
    assign wr_ok = we && addr_ok && !game_over;
    assign werr  = 1'b0;
`endif

    always_comb begin
        int unsigned li, pos;
        logic [1:0]  code;
        li      = int'(idx_q);
        pos     = 0;
        code    = 2'b00;
        line_p1 = 1'b1;
        line_p2 = 1'b1;
        line_nz = 1'b1;
        for (int unsigned k = 0; k < DIM; k++) begin
            if (li < DIM)            pos = li * DIM + k + 1;
            else if (li < 2 * DIM)   pos = k * DIM + (li - DIM) + 1;
            else if (li == 2 * DIM)  pos = k * DIM + k + 1;
            else                     pos = k * DIM + (DIM - 1 - k) + 1;
            code    = ram_q[ADDR_W'(pos)];
            line_p1 = line_p1 & (code == 2'b01);
            line_p2 = line_p2 & (code == 2'b10);
            line_nz = line_nz & (code != 2'b00);
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (wr_ok) begin
            state_d = SCAN;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                SCAN:    if (last_line) state_d = FINISH;
                FINISH:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    always_comb begin
        ram_d         = ram_q;
        addr_reg_d    = addr;
        idx_d         = idx_q;
        p1_d          = p1_q;
        p2_d          = p2_q;
        full_d        = full_q;
        state_final_d = state_final_q;
        done_d        = 1'b0;
        if (wr_ok) begin
            ram_d[addr] = data;
            idx_d       = '0;
            p1_d        = 1'b0;
            p2_d        = 1'b0;
            full_d      = 1'b1;
        end else if (state_q == SCAN) begin
            p1_d = p1_q | line_p1;
            p2_d = p2_q | line_p2;
            // Every cell lies on exactly one row, so rows alone decide fullness.
            if (idx_q < ROW_END) full_d = full_q & line_nz;
            if (!last_line) idx_d = idx_q + 1'b1;
        end else if (state_q == FINISH) begin
            state_final_d = (p1_q | p2_q) ? {p2_q, p1_q} : {full_q, full_q};
            done_d        = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            ram_q         <= '{default: '0};
            addr_reg_q    <= '0;
            idx_q         <= '0;
            p1_q          <= 1'b0;
            p2_q          <= 1'b0;
            full_q        <= 1'b0;
            state_final_q <= '0;
            done_q        <= 1'b0;
        end else begin
            ram_q         <= ram_d;
            addr_reg_q    <= addr_reg_d;
            idx_q         <= idx_d;
            p1_q          <= p1_d;
            p2_q          <= p2_d;
            full_q        <= full_d;
            state_final_q <= state_final_d;
            done_q        <= done_d;
        end
    end

    assign Q           = ((addr_reg_q != '0) && (addr_reg_q <= LAST_ADDR)) ? ram_q[addr_reg_q] : 2'b00;
    assign state_final = state_final_q;
    assign done        = done_q;
    assign game_over   = (state_final_q != 2'b00);

endmodule

// File: tb/tb_board_state_scanner.sv
// Directed + randomized bench for board_state_scanner against a board-level reference model.
module tb_board_state_scanner;
    localparam int unsigned DIM = 3;
    localparam int unsigned N   = DIM * DIM;
    localparam int unsigned LAT = 2 * DIM + 3;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       we = 1'b0;
    logic [1:0] data = 2'b00;
    logic [3:0] addr = 4'd0;
    logic [1:0] Q, state_final;
    logic       busy, done, game_over, werr;

    logic       we4 = 1'b0;
    logic [1:0] data4 = 2'b00;
    logic [4:0] addr4 = 5'd0;
    logic [1:0] Q4, state_final4;
    logic       busy4, done4, game_over4, werr4;

    int n_chk = 0;
    int n_err = 0;

    logic [1:0]  board_m [0:15];
    int          cnt_m;
    logic [1:0]  sf_m;
    logic        done_m, werr_m;
    int unsigned areg_m;

    always #5 clk = ~clk;

    board_state_scanner #(.DIM(3), .ADDR_W(4)) dut (
        .clk(clk), .clear(clear), .we(we), .data(data), .addr(addr), .Q(Q),
        .state_final(state_final), .busy(busy), .done(done), .game_over(game_over), .werr(werr)
    );

    board_state_scanner #(.DIM(4), .ADDR_W(5)) dut4 (
        .clk(clk), .clear(clear), .we(we4), .data(data4), .addr(addr4), .Q(Q4),
        .state_final(state_final4), .busy(busy4), .done(done4), .game_over(game_over4), .werr(werr4)
    );

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] judge();
        bit p1, p2, full, a1, a2;
        int r, c;
        p1 = 0; p2 = 0; full = 1;
        for (int l = 0; l < 2 * DIM + 2; l++) begin
            a1 = 1; a2 = 1;
            for (int k = 0; k < DIM; k++) begin
                if (l < DIM)            begin r = l; c = k;           end
                else if (l < 2 * DIM)   begin r = k; c = l - DIM;     end
                else if (l == 2 * DIM)  begin r = k; c = k;           end
                else                    begin r = k; c = DIM - 1 - k; end
                a1 = a1 & (board_m[r * DIM + c + 1] == 2'b01);
                a2 = a2 & (board_m[r * DIM + c + 1] == 2'b10);
            end
            p1 = p1 | a1;
            p2 = p2 | a2;
        end
        for (int i = 1; i <= N; i++) full = full & (board_m[i] != 2'b00);
        return (p1 | p2) ? {p2, p1} : {full, full};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) board_m[i] = 2'b00;
        cnt_m = 0; sf_m = 2'b00; done_m = 0; werr_m = 0; areg_m = 0;
    endtask

    task automatic model_edge(input bit w, input int unsigned a, input logic [1:0] d);
        bit acc;
        acc = w && (a >= 1) && (a <= N) && (sf_m == 2'b00);
`ifdef WRITE_PROTECT_EN
        acc = acc && (board_m[a] == 2'b00);
        werr_m = w && !acc;
`else
        werr_m = 0;
`endif
        done_m = 0;
        if (acc) begin
            board_m[a] = d;
            cnt_m = LAT;
        end else if (cnt_m > 0) begin
            cnt_m--;
            if (cnt_m == 0) begin
                sf_m = judge();
                done_m = 1;
            end
        end
        areg_m = a;
    endtask

    task automatic compare_all();
        chk("busy", {1'b0, busy}, {1'b0, cnt_m > 0});
        chk("done", {1'b0, done}, {1'b0, done_m});
        chk("state_final", state_final, sf_m);
        chk("game_over", {1'b0, game_over}, {1'b0, sf_m != 2'b00});
        chk("Q", Q, ((areg_m >= 1) && (areg_m <= N)) ? board_m[areg_m] : 2'b00);
        chk("werr", {1'b0, werr}, {1'b0, werr_m});
    endtask

    task automatic step(input bit w, input int unsigned a, input logic [1:0] d);
        we = w; addr = 4'(a); data = d;
        @(posedge clk);
        model_edge(w, a, d);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, areg_m, 2'b00);
    endtask

    task automatic do_reset();
        clear = 1'b1;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        clear = 1'b0;
        we = 1'b0;
    endtask

    task automatic step4(input bit w, input int unsigned a, input logic [1:0] d);
        we4 = w; addr4 = 5'(a); data4 = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ndone;
        logic [1:0] fill [9];
        model_reset();
        #2;
        do_reset();

        // P1 wins on the top row
        step(1, 1, 2'b01); step(1, 2, 2'b01); step(1, 3, 2'b01);
        idle(8);
        chk("row_busy_held", {1'b0, busy}, 2'b01);
        chk("row_no_early_done", {1'b0, done}, 2'b00);
        idle(1);
        chk("row_done", {1'b0, done}, 2'b01);
        chk("row_result", state_final, 2'b01);
        chk("row_game_over", {1'b0, game_over}, 2'b01);
        idle(1);
        chk("row_done_pulse", {1'b0, done}, 2'b00);

        // P2 anti-diagonal, later writes locked out
        do_reset();
        step(1, 3, 2'b10); step(1, 5, 2'b10); step(1, 7, 2'b10);
        idle(9);
        chk("anti_result", state_final, 2'b10);
        step(1, 1, 2'b01);
        step(0, 1, 2'b00);
        chk("locked_q", Q, 2'b00);
        chk("locked_busy", {1'b0, busy}, 2'b00);

        // Full board without a line is a draw
        do_reset();
        fill = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11};
        for (int i = 0; i < 9; i++) step(1, i + 1, fill[i]);
        idle(9);
        chk("draw_result", state_final, 2'b11);

        // Drawn cells never complete a line
        do_reset();
        step(1, 1, 2'b11); step(1, 5, 2'b11); step(1, 9, 2'b11);
        idle(10);
        chk("x11_result", state_final, 2'b00);
        chk("x11_game_over", {1'b0, game_over}, 2'b00);

        // A second write mid-scan restarts it: exactly one done
        do_reset();
        ndone = 0;
        step(1, 1, 2'b01);
        for (int i = 0; i < 3; i++) begin idle(1); ndone += int'(done); end
        step(1, 2, 2'b01); ndone += int'(done);
        for (int i = 0; i < 8; i++) begin idle(1); ndone += int'(done); end
        chk("restart_no_done_yet", {1'b0, done}, 2'b00);
        idle(1); ndone += int'(done);
        chk("restart_done", {1'b0, done}, 2'b01);
        idle(2); ndone += int'(done);
        chk("restart_single_done", 2'(ndone), 2'b01);

        // Clear mid-scan, then an address-0 write
        do_reset();
        step(1, 1, 2'b01);
        step(0, 1, 2'b00);
        chk("pre_clear_q", Q, 2'b01);
        do_reset();
        chk("clear_busy", {1'b0, busy}, 2'b00);
        step(1, 0, 2'b01);
        chk("addr0_busy", {1'b0, busy}, 2'b00);
        step(1, 12, 2'b10);
        chk("oob_busy", {1'b0, busy}, 2'b00);

        // Randomized play against the model
        do_reset();
        for (int it = 0; it < 600; it++) begin
            if (sf_m != 2'b00 && $urandom_range(0, 3) == 0) do_reset();
            else if ($urandom_range(0, 5) == 0) idle(int'($urandom_range(1, LAT + 1)));
            else step($urandom_range(0, 2) != 0, $urandom_range(0, 15), 2'($urandom_range(0, 3)));
        end

        // 4x4 board, anti-diagonal win for P1
        do_reset();
        step4(1, 4, 2'b01); step4(1, 7, 2'b01); step4(1, 10, 2'b01); step4(1, 13, 2'b01);
        for (int i = 0; i < 10; i++) step4(0, 4, 2'b00);
        chk("d4_busy_held", {1'b0, busy4}, 2'b01);
        chk("d4_no_early_done", {1'b0, done4}, 2'b00);
        step4(0, 4, 2'b00);
        chk("d4_done", {1'b0, done4}, 2'b01);
        chk("d4_result", state_final4, 2'b01);
        chk("d4_q", Q4, 2'b01);
        step4(1, 4, 2'b10);
`ifdef WRITE_PROTECT_EN
        chk("d4_werr", {1'b0, werr4}, 2'b01);
`else
        chk("d4_werr", {1'b0, werr4}, 2'b00);
`endif
        chk("d4_reject_busy", {1'b0, busy4}, 2'b00);
        step4(0, 4, 2'b00);
        chk("d4_werr_pulse", {1'b0, werr4}, 2'b00);
        chk("d4_q_kept", Q4, 2'b01);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
